// File: rtl/img_pingpong_buffer.sv
// Double-buffered image capture: one bank fills from a valid/ready beat stream
// while the other presents a complete frame to the classifier until consumed.
module img_pingpong_buffer #(
    parameter  int IMG_WIDTH   = 30,
    parameter  int IMG_HEIGHT  = 30,
    parameter  int DATA_W      = 8,
    parameter  int BIT_REVERSE = 0,
    localparam int BEATS       = (IMG_WIDTH * IMG_HEIGHT + DATA_W - 1) / DATA_W,
    localparam int TOTAL_BITS  = BEATS * DATA_W,
    localparam int CNT_W       = $clog2(BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  frame_valid,
    output logic [TOTAL_BITS-1:0] img_out,
    input  logic                  frame_consume,
    output logic [CNT_W-1:0]      fill_count,
    output logic                  frame_pending
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   fill_count_reg, fill_count_next;
    logic               frame_valid_reg, frame_valid_next;
    logic               rd_sel_reg, rd_sel_next;

    logic               accept;
    logic               last_beat;
    logic               consume_ok;
    logic               swap;
    logic [DATA_W-1:0]  wdata;

    // Handshake outputs depend only on state and reset, never on the inputs.
    assign s_ready       = rst_n && (state_reg == ST_FILL);
    assign frame_pending = rst_n && (state_reg == ST_HOLD);
    assign fill_count    = fill_count_reg;
    assign frame_valid   = frame_valid_reg;

    assign accept     = s_ready && s_valid && !clear;
    assign last_beat  = accept && (fill_count_reg == LAST_IDX);
    assign consume_ok = frame_consume && frame_valid_reg;
    // A pending frame discarded by clear must never be swapped in.
    assign swap = (last_beat && (!frame_valid_reg || consume_ok)) ||
                  ((state_reg == ST_HOLD) && consume_ok && !clear);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            if (BIT_REVERSE != 0) begin : g_rev
                assign wdata[gi] = s_data[DATA_W-1-gi];
            end else begin : g_fwd
                assign wdata[gi] = s_data[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        fill_count_next  = fill_count_reg;
        frame_valid_next = frame_valid_reg;
        rd_sel_next      = rd_sel_reg;

        if (swap) begin
            state_next       = ST_FILL;
            fill_count_next  = '0;
            frame_valid_next = 1'b1;
            rd_sel_next      = !rd_sel_reg;
        end else begin
            if (consume_ok) begin
                frame_valid_next = 1'b0;
            end
            if (clear) begin
                state_next      = ST_FILL;
                fill_count_next = '0;
            end else if (accept) begin
                fill_count_next = fill_count_reg + CNT_W'(1);
                if (last_beat) begin
                    state_next = ST_HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_FILL;
            fill_count_reg  <= '0;
            frame_valid_reg <= 1'b0;
            rd_sel_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fill_count_reg  <= fill_count_next;
            frame_valid_reg <= frame_valid_next;
            rd_sel_reg      <= rd_sel_next;
        end
    end

    // One register pair per beat slot; bank 0 is read when rd_sel is 0.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [DATA_W-1:0] b0_reg;
            logic [DATA_W-1:0] b1_reg;
            logic              wr_hit;

            assign wr_hit = accept && (fill_count_reg == CNT_W'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    b0_reg <= '0;
                    b1_reg <= '0;
                end else if (wr_hit) begin
                    if (rd_sel_reg) begin
                        b0_reg <= wdata;
                    end else begin
                        b1_reg <= wdata;
                    end
                end
            end

            assign img_out[gi*DATA_W +: DATA_W] = rd_sel_reg ? b1_reg : b0_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (32'(fill_count_reg) <= 32'(BEATS));
            assert (!(accept && (state_reg == ST_HOLD)));
        end
    end

endmodule

// File: tb/tb_img_pingpong_buffer.sv
// Directed bench: default 30x30x8 buffer plus a 3x3 1-bit and an 8x1 reversed variant.
module tb_img_pingpong_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         rst_n;
    logic         clear;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic         frame_valid;
    logic [903:0] img_out;
    logic         frame_consume;
    logic [6:0]   fill_count;
    logic         frame_pending;

    logic         s1_clear, s1_data, s1_valid, s1_ready, s1_fv, s1_consume, s1_pending;
    logic [8:0]   s1_img;
    logic [3:0]   s1_count;

    logic         s2_clear, s2_valid, s2_ready, s2_fv, s2_consume, s2_pending;
    logic [7:0]   s2_data, s2_img;
    logic [0:0]   s2_count;

    img_pingpong_buffer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .frame_valid(frame_valid), .img_out(img_out),
        .frame_consume(frame_consume), .fill_count(fill_count), .frame_pending(frame_pending)
    );

    img_pingpong_buffer #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_W(1), .BIT_REVERSE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(s1_clear), .s_data(s1_data), .s_valid(s1_valid),
        .s_ready(s1_ready), .frame_valid(s1_fv), .img_out(s1_img),
        .frame_consume(s1_consume), .fill_count(s1_count), .frame_pending(s1_pending)
    );

    img_pingpong_buffer #(.IMG_WIDTH(8), .IMG_HEIGHT(1), .DATA_W(8), .BIT_REVERSE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(s2_clear), .s_data(s2_data), .s_valid(s2_valid),
        .s_ready(s2_ready), .frame_valid(s2_fv), .img_out(s2_img),
        .frame_consume(s2_consume), .fill_count(s2_count), .frame_pending(s2_pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat k of a frame started at 'base' is expected to hold base+k.
    task automatic chk_frame(input string tag, input logic [7:0] base);
        int nbad;
        nbad = 0;
        for (int k = 0; k < 113; k++) begin
            if (img_out[k*8 +: 8] !== base + 8'(k)) nbad++;
        end
        chk(tag, 32'(nbad), 32'd0);
    endtask

    task automatic send_beats(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = first + 8'(k);
            tick();
        end
        s_valid = 1'b0;
    endtask

    logic [8:0] pat;
    int drops;
    int pends;

    initial begin
        rst_n = 1'b0; clear = 1'b0; s_data = '0; s_valid = 1'b0; frame_consume = 1'b0;
        s1_clear = 1'b0; s1_data = 1'b0; s1_valid = 1'b0; s1_consume = 1'b0;
        s2_clear = 1'b0; s2_data = '0; s2_valid = 1'b0; s2_consume = 1'b0;
        pat = 9'h14D;
        tick();
        tick();
        chk("ready_in_reset", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(s_ready), 32'd1);
        chk("reset_fv", 32'(frame_valid), 32'd0);
        chk("reset_count", 32'(fill_count), 32'd0);
        chk("reset_pending", 32'(frame_pending), 32'd0);
        chk("reset_img_zero", 32'(|img_out), 32'd0);
        tick();
        $display("txn: reset released");

        // 1-bit, 3x3, reversed: nine beats make a frame
        for (int k = 0; k < 9; k++) begin
            s1_valid = 1'b1;
            s1_data  = pat[k];
            if (k == 8) chk("w1_fv_before_last", 32'(s1_fv), 32'd0);
            tick();
        end
        s1_valid = 1'b0;
        chk("w1_fv", 32'(s1_fv), 32'd1);
        chk("w1_img", 32'(s1_img), 32'h14D);
        chk("w1_count", 32'(s1_count), 32'd0);
        $display("txn: dw1 frame img=%h", s1_img);

        // 8-bit reversed: 0xA0 lands as 0x05
        s2_valid = 1'b1; s2_data = 8'hA0;
        tick();
        s2_valid = 1'b0;
        chk("rev8_fv", 32'(s2_fv), 32'd1);
        chk("rev8_img", 32'(s2_img), 32'h05);
        $display("txn: rev8 beat a0 img=%h", s2_img);

        // Frame A: 0x00..0x70
        send_beats(8'h00, 112);
        chk("A_fv_before_last", 32'(frame_valid), 32'd0);
        chk("A_count_112", 32'(fill_count), 32'd112);
        send_beats(8'h70, 1);
        chk("A_fv", 32'(frame_valid), 32'd1);
        chk("A_low_byte", 32'(img_out[7:0]), 32'h00);
        chk("A_high_byte", 32'(img_out[903:896]), 32'h70);
        chk("A_count", 32'(fill_count), 32'd0);
        chk_frame("A_frame", 8'h00);
        $display("txn: frame A complete");

        // Frame B without consume -> HOLD
        send_beats(8'h80, 113);
        chk("B_pending", 32'(frame_pending), 32'd1);
        chk("B_ready", 32'(s_ready), 32'd0);
        chk("B_count", 32'(fill_count), 32'd113);
        chk_frame("B_A_kept", 8'h00);
        frame_consume = 1'b1;
        tick();
        frame_consume = 1'b0;
        chk("B_fv", 32'(frame_valid), 32'd1);
        chk("B_ready_after", 32'(s_ready), 32'd1);
        chk("B_pending_after", 32'(frame_pending), 32'd0);
        chk("B_count_after", 32'(fill_count), 32'd0);
        chk_frame("B_frame", 8'h80);
        $display("txn: frame B swapped in from hold");

        // Frame C: last beat coincides with consume
        drops = 0; pends = 0;
        for (int k = 0; k < 113; k++) begin
            s_valid = 1'b1;
            s_data  = 8'h10 + 8'(k);
            frame_consume = (k == 112);
            tick();
            if (!frame_valid) drops++;
            if (frame_pending) pends++;
        end
        s_valid = 1'b0; frame_consume = 1'b0;
        chk("C_fv_drops", 32'(drops), 32'd0);
        chk("C_pending_cycles", 32'(pends), 32'd0);
        chk("C_ready", 32'(s_ready), 32'd1);
        chk("C_count", 32'(fill_count), 32'd0);
        chk_frame("C_frame", 8'h10);
        $display("txn: frame C back-to-back swap");

        frame_consume = 1'b1;
        tick();
        frame_consume = 1'b0;
        chk("C_consumed_fv", 32'(frame_valid), 32'd0);
        chk_frame("C_img_kept", 8'h10);
        $display("txn: frame C consumed");

        // 50 beats then clear with a live beat
        send_beats(8'hEE, 50);
        chk("clr_count_50", 32'(fill_count), 32'd50);
        s_valid = 1'b1; s_data = 8'h55; clear = 1'b1;
        tick();
        s_valid = 1'b0; clear = 1'b0;
        chk("clr_count", 32'(fill_count), 32'd0);
        send_beats(8'h03, 113);
        chk("D_fv", 32'(frame_valid), 32'd1);
        chk_frame("D_frame", 8'h03);
        $display("txn: clear then frame D");

        // clear on the completing beat: dropped, no swap
        send_beats(8'h40, 112);
        s_valid = 1'b1; s_data = 8'hB0; clear = 1'b1;
        tick();
        s_valid = 1'b0; clear = 1'b0;
        chk("clrlast_count", 32'(fill_count), 32'd0);
        chk("clrlast_pending", 32'(frame_pending), 32'd0);
        chk("clrlast_ready", 32'(s_ready), 32'd1);
        chk("clrlast_fv", 32'(frame_valid), 32'd1);
        chk_frame("clrlast_D_kept", 8'h03);
        $display("txn: clear on last beat");

        // Reset mid-frame with a frame valid
        send_beats(8'h20, 20);
        rst_n = 1'b0;
        tick();
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_count", 32'(fill_count), 32'd0);
        chk("rst_img_zero", 32'(|img_out), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_w1_img", 32'(s1_img), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_after", 32'(s_ready), 32'd1);
        tick();
        chk("rst_count_after", 32'(fill_count), 32'd0);
        $display("txn: mid-frame reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_pingpong_buffer.md
# img_pingpong_buffer

Double-buffered, parametrised image capture buffer between the byte-stream receive path and the BNN classifier. One bank fills from a valid/ready beat stream while the other bank holds a complete frame for the classifier. The classifier releases its frame with a consume pulse. Frame size, beat width and intra-beat bit order are parameters. The fill side never overwrites a frame the classifier is still reading.

## Interface

Parameters:
- IMG_WIDTH, 30, image width in pixels (1 bit per pixel)
- IMG_HEIGHT, 30, image height in pixels
- DATA_W, 8, beat width in bits; legal values 1, 2, 4, 8, 16, 32
- BIT_REVERSE, 0, 0: s_data[DATA_W-1] lands at the MSB of its slice; 1: s_data[0] lands at the MSB of its slice
- Derived localparams:
  - BEATS = ceil(IMG_WIDTH*IMG_HEIGHT / DATA_W)
  - TOTAL_BITS = BEATS*DATA_W (904 at defaults)
  - CNT_W = $clog2(BEATS+1)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  abort current fill: drop partial or pending frame; read bank unaffected
- s_data  in  DATA_W  pixel beat
- s_valid  in  1  beat valid
- s_ready  out  1  fill bank can accept a beat
- frame_valid  out  1  img_out holds a complete, unconsumed frame
- img_out  out  TOTAL_BITS  read-bank contents; beat k occupies bits [k*DATA_W +: DATA_W]
- frame_consume  in  1  one-cycle pulse from the classifier releasing the read bank
- fill_count  out  CNT_W  beats accepted into the fill bank for the current frame
- frame_pending  out  1  fill bank is complete and waiting for the read bank to free

## Operation

- Storage: two registered banks, each TOTAL_BITS wide.
  - rd_sel selects the read bank; the fill bank is !rd_sel.
- Fill FSM has two states.
  - FILL: s_ready=1.
    - A beat is accepted when s_valid && s_ready && !clear.
    - An accepted beat is written to fill bank [fill_count*DATA_W +: DATA_W], with bit order per BIT_REVERSE, and fill_count increments.
    - On accepting beat BEATS-1: if the read bank is free (frame_valid=0) or is being consumed this cycle, swap and stay in FILL. Otherwise go to HOLD.
  - HOLD: s_ready=0, frame_pending=1, fill_count=BEATS.
    - A frame_consume with frame_valid=1 triggers a swap and a return to FILL.
- Swap, effective next cycle:
  - rd_sel toggles.
  - frame_valid=1.
  - fill_count=0.
  - The old read bank becomes the fill bank. It is not zeroed, because every bit is overwritten by the next frame.
- Consume:
  - frame_consume with frame_valid=1 and nothing completing or pending: frame_valid=0 next cycle. img_out keeps its last contents.
  - frame_consume with frame_valid=0 is ignored.
- clear:
  - Next cycle: fill_count=0, FSM=FILL, frame_pending=0.
  - clear overrides a same-cycle beat; the beat is dropped, not written.
  - clear in the same cycle as completing beat BEATS-1: the beat is dropped and no swap occurs.
  - clear has no effect on frame_valid, rd_sel or img_out.
  - A simultaneous frame_consume is still honoured, except that it cannot swap in the discarded pending frame.
- Reset (rst_n=0 at a posedge):
  - Both banks zero; rd_sel=0; FSM=FILL.
  - fill_count=0, frame_valid=0, frame_pending=0.
  - s_ready is held 0 while rst_n=0.
  - Reset mid-frame discards all data.

## Timing

- s_ready and frame_pending are combinational from FSM state and rst_n only. They have no dependence on s_valid, clear or frame_consume.
- Throughput: one beat per cycle.
- Latency: frame_valid rises 1 cycle after the posedge that accepts beat BEATS-1.
- A back-to-back frame completing in the same cycle as frame_consume swaps with no frame_valid bubble. img_out changes on that edge.
- From HOLD: the consume edge swaps, and s_ready=1 on the next cycle.
- img_out is a combinational mux of registers. It is stable for the whole time frame_valid=1 and changes only on a swap edge.
- Simulation assertions:
  - fill_count ≤ BEATS.
  - No write occurs while FSM=HOLD.

## Test plan

- Defaults (113 beats). Stream beats 0x00..0x70, one per cycle, with frame_valid=0 before the stream. Required: frame_valid=1 one cycle after the last beat; img_out[7:0]=0x00; img_out[903:896]=0x70; fill_count=0.
- Without consuming, stream a second full frame. Required: frame_pending=1 and s_ready=0 after beat 112, and the first frame is unchanged on img_out. Pulse frame_consume: img_out shows the second frame next cycle, frame_valid stays 1, s_ready=1.
- Second frame's last beat accepted in the same cycle as frame_consume. Required: swap on that edge, frame_valid never drops, HOLD never entered.
- Send 50 beats, then clear with s_valid=1. Required: the beat in the clear cycle is dropped, fill_count=0 next cycle. A following full 113-beat frame lands correctly with no residue.
- DATA_W=1, IMG 3x3, BIT_REVERSE=1; also DATA_W=8 with BIT_REVERSE=1 and beat 0xA0. Required: BEATS=9, TOTAL_BITS=9, frame_valid after 9 beats; img_out[7:0]=0x05.
- Assert rst_n=0 mid-frame and while frame_valid=1. Required next cycle: frame_valid=0, fill_count=0, img_out=0, s_ready=0 during reset and 1 after.
